div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Parametrised iterative radix-2 restoring divider. Next generation of the pipeline's fixed 32-bit divide unit.
- Driven by the EX stage: EX raises start, holds its stall request until ready, and uses annul to kill an in-flight divide on a flush.
- Adds over the current unit:
  - configurable operand width;
  - an explicit busy indication;
  - a divide-by-zero flag;
  - a defined signed-overflow result;
  - an optional early-termination mode.

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned.
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- start_i  input  1  request; level-held by EX until ready_o is seen.
- annul_i  input  1  abort the in-flight operation.
- result_o  output  2*WIDTH  {remainder, quotient}.
- ready_o  output  1  result valid.
- busy_o  output  1  operation in progress.
- div_by_zero_o  output  1  divisor was zero; valid while ready_o=1.

Behaviour:
- Reset: rst=1 at a rising edge forces state IDLE and all outputs to 0, including mid-operation. The counter and internal registers clear.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 captures opdata1_i, opdata2_i and signed_div_i. Later input changes are ignored.
  - Divisor==0 goes to BYZERO; otherwise goes to ON with counter=0.
  - start_i=1 together with annul_i=1 is not accepted.
- ON, first cycle:
  - If signed_div_i=1, negative operands are replaced by their magnitudes and both signs are retained.
  - Each ON cycle: shift the partial remainder left by 1 bit.
  - If the result is >= the divisor magnitude, subtract and shift in quotient bit 1; otherwise shift in 0.
- ON, exit: after WIDTH iterations go to END. In END:
  - quotient is negated if sign1^sign2;
  - remainder is negated if sign1 (remainder takes the dividend's sign);
  - unsigned mode applies no sign fix.
- BYZERO: after one cycle go to END with result 0 and div_by_zero_o=1.
- END:
  - ready_o=1; result_o and div_by_zero_o are held stable.
  - Stays in END while start_i=1. start_i=0 goes to IDLE, and ready_o, result_o and div_by_zero_o return to 0 on that edge.
- annul_i=1 in ON or BYZERO: go to IDLE next edge; ready_o never asserts. annul_i is ignored in IDLE and END.
- busy_o=1 exactly in BYZERO and ON.
- start_i is ignored outside IDLE.
- Latency (base build), counted from the accepting edge:
  - ready_o first high after WIDTH+1 edges, i.e. 33 cycles at WIDTH=32.
  - Divide-by-zero: 2 edges.
- Signed overflow: (-2^(WIDTH-1)) / (-1) gives quotient 2^(WIDTH-1) (wrapped) and remainder 0. No flag.
- Arithmetic: the partial remainder is WIDTH+1 bits, so the subtract-and-compare never overflows. All negation is two's-complement modulo 2^WIDTH.
- Back-to-back: after END→IDLE, a new start_i may be accepted on the next edge.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - On acceptance, count the leading zeros lz of the dividend magnitude.
  - Pre-shift the dividend by lz.
  - Run max(1, WIDTH-lz) iterations; latency becomes max(1, WIDTH-lz)+1 edges.
  - A zero dividend takes 2 edges with result 0.
  - Results are bit-identical to the base build.
- Undefined: always WIDTH iterations. No leading-zero counter is synthesised.

Test Plan:
- WIDTH=32, unsigned, 100/7, start held → ready_o rises 33 cycles after accept; result_o = {32'd2, 32'd14}; busy_o high 32 cycles; div_by_zero_o=0.
- Signed -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Any/0 → ready_o after 2 edges; result 0; div_by_zero_o=1; flag clears when start_i drops.
- annul_i pulsed 10 cycles into a divide → IDLE next edge, ready_o stays 0, busy_o drops. A new start 1 cycle later gives the correct 50/5 = {0, 10}.
- rst asserted mid-ON and start held through reset → all outputs 0 after the reset edge. After rst drops, the held start is re-accepted and 9/3 = {0, 3} completes normally.
- Dividend changed after accept, and start held 5 extra cycles in END → result unaffected and stable through END; drops to 0 on the edge after start_i=0.
- With DIV_EARLY_OUT_EN, 100/7 at WIDTH=32 (lz=25) → ready_o after 8 edges, same result; random 10k signed/unsigned pairs match the base build.
- WIDTH=8 unsigned, 255/16 → {8'd15, 8'd15} after 9 edges.

Source files
------------

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, {remainder, quotient} result, signed or unsigned.
// Optional early termination via leading-zero pre-shift when DIV_EARLY_OUT_EN is defined.
module div_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o,
   output logic               div_by_zero_o,
   output logic [1:0]         dbg_state_o
);

   // Handshake: start_i is a level request held until ready_o; ready_o stays
   // high with a stable result until start_i drops, then clears on that edge.
   typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   dvs_q;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   last_q;
   logic               neg_quo_q;
   logic               neg_rem_q;
   logic [2*WIDTH-1:0] result_q;
   logic               dbz_q;

   logic               accept;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   dividend_init;
   logic [CNT_W-1:0]   last_init;
   logic [WIDTH:0]     shifted, diff;
   logic               ge;
   logic [WIDTH-1:0]   rem_n, quo_n;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef DIV_EARLY_OUT_EN
   logic [CNT_W-1:0]   lz;

   // Ascending scan so the highest set bit decides; all-zero yields WIDTH.
   function automatic logic [CNT_W-1:0] count_lz(input logic [WIDTH-1:0] v);
      count_lz = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) count_lz = CNT_W'(WIDTH - 1 - i);
      end
   endfunction
`endif

   assign accept = start_i & ~annul_i;
   assign a_neg  = signed_div_i & opdata1_i[WIDTH-1];
   assign b_neg  = signed_div_i & opdata2_i[WIDTH-1];
   assign a_mag  = a_neg ? (WIDTH'(0) - opdata1_i) : opdata1_i;
   assign b_mag  = b_neg ? (WIDTH'(0) - opdata2_i) : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
   assign lz            = count_lz(a_mag);
   assign dividend_init = a_mag << lz;
   assign last_init     = (lz >= CNT_W'(WIDTH)) ? '0 : (CNT_W'(WIDTH - 1) - lz);
`else
   assign dividend_init = a_mag;
   assign last_init     = CNT_W'(WIDTH - 1);
`endif

   // One restoring step; the WIDTH+1-bit partial remainder cannot overflow.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_q};
      ge      = (shifted >= {1'b0, dvs_q});
      rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_n   = {quo_q[WIDTH-2:0], ge};
      quo_fix = neg_quo_q ? (WIDTH'(0) - quo_n) : quo_n;
      rem_fix = neg_rem_q ? (WIDTH'(0) - rem_n) : rem_n;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
         end
         S_BYZERO: state_d = annul_i ? S_IDLE : S_END;
         S_ON: begin
            if (annul_i)               state_d = S_IDLE;
            else if (cnt_q == last_q)  state_d = S_END;
         end
         S_END: begin
            if (!start_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dvs_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         last_q    <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         dbz_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  dvs_q     <= b_mag;
                  rem_q     <= '0;
                  quo_q     <= dividend_init;
                  cnt_q     <= '0;
                  last_q    <= last_init;
                  neg_quo_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
               end
            end
            S_BYZERO: begin
               if (!annul_i) begin
                  result_q <= '0;
                  dbz_q    <= 1'b1;
               end
            end
            S_ON: begin
               if (!annul_i) begin
                  rem_q <= rem_n;
                  quo_q <= quo_n;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == last_q) result_q <= {rem_fix, quo_fix};
               end
            end
            S_END: begin
               if (!start_i) begin
                  result_q <= '0;
                  dbz_q    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign result_o      = result_q;
   assign div_by_zero_o = dbz_q;
   assign ready_o       = (state_q == S_END);
   assign busy_o        = (state_q == S_BYZERO) || (state_q == S_ON);
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: vector table, hand-written corner sequences and random
// operands checked against an arithmetic reference model.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic        start_i, annul_i;
   logic [63:0] result_o;
   logic        ready_o, busy_o, div_by_zero_o;
   logic [1:0]  dbg_state_o;

   logic        start8;
   logic [7:0]  a8, b8;
   logic [15:0] res8;
   logic        rdy8, busy8, dbz8;
   logic [1:0]  dbg8;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div_iter #(.WIDTH(32), .CNT_W(7)) u_dut (
      .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
      .start_i(start_i), .annul_i(annul_i),
      .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o),
      .div_by_zero_o(div_by_zero_o), .dbg_state_o(dbg_state_o)
   );

   div_iter #(.WIDTH(8), .CNT_W(4)) u_dut8 (
      .clk(clk), .rst(rst), .signed_div_i(1'b0),
      .opdata1_i(a8), .opdata2_i(b8),
      .start_i(start8), .annul_i(1'b0),
      .result_o(res8), .ready_o(rdy8), .busy_o(busy8),
      .div_by_zero_o(dbz8), .dbg_state_o(dbg8)
   );

   typedef struct {
      bit          sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp_res;
      bit          exp_dbz;
      int          hold;
   } vec_t;

   vec_t tbl[12];

   // Reference: language division truncates toward zero, remainder follows dividend.
   function automatic logic [63:0] model_res(input bit sg, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {32'(r), 32'(q)};
   endfunction

   function automatic int model_lat(input bit sg, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] mag;
      int lz, n;
      if (b == 32'd0) return 2;
      mag = (sg && a[31]) ? (32'd0 - a) : a;
      lz = 32;
      for (int i = 31; i >= 0; i--) begin
         if (mag[i]) begin
            lz = 31 - i;
            break;
         end
      end
`ifdef DIV_EARLY_OUT_EN
      n = 32 - lz;
      if (n < 1) n = 1;
`else
      n = 32;
`endif
      return n + 1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Waits from the accepting edge to ready, verifies, holds, then releases start.
   task automatic finish_div(input string name, input logic [63:0] exp_res, input bit exp_dbz,
                             input int exp_lat, input int hold);
      int lat, busy_cnt;
      bit done;
      lat = 0; busy_cnt = 0; done = 0;
      while (!done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (busy_o) busy_cnt++;
         if (lat == 1) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~signed_div_i;
         end
         if (ready_o) done = 1;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: ready_o never rose within 200 cycles", name);
      end
      check({name, "_res"}, result_o, exp_res);
      check({name, "_dbz"}, 64'(div_by_zero_o), 64'(exp_dbz));
      check({name, "_lat"}, 64'(lat), 64'(exp_lat));
      check({name, "_busy"}, 64'(busy_cnt), 64'(exp_lat - 1));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, "_hold_res"}, result_o, exp_res);
         check({name, "_hold_rdy"}, 64'(ready_o), 64'd1);
      end
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
      check({name, "_clr_rdy"}, 64'(ready_o), 64'd0);
      check({name, "_clr_res"}, result_o, 64'd0);
      check({name, "_clr_dbz"}, 64'(div_by_zero_o), 64'd0);
   endtask

   task automatic run_vec(input string name, input bit sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input bit exp_dbz, input int hold);
      @(negedge clk);
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      annul_i      = 1'b0;
      start_i      = 1'b1;
      finish_div(name, exp_res, exp_dbz, model_lat(sg, a, b), hold);
   endtask

   initial begin
      tbl[0]  = '{0, 32'd100,        32'd7,          {32'd2, 32'd14},                 0, 5};
      tbl[1]  = '{1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    0, 0};
      tbl[2]  = '{1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},           0, 0};
      tbl[3]  = '{0, 32'd5,          32'd0,          64'd0,                           1, 2};
      tbl[4]  = '{1, 32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE, 32'hFFFFFFF2},    0, 0};
      tbl[5]  = '{1, 32'd100,        32'hFFFFFFF9,   {32'd2, 32'hFFFFFFF2},           0, 0};
      tbl[6]  = '{0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF},           0, 0};
      tbl[7]  = '{0, 32'd0,          32'd9,          64'd0,                           0, 0};
      tbl[8]  = '{0, 32'd1000000,    32'd7,          {32'd1, 32'd142857},             0, 0};
      tbl[9]  = '{1, 32'hFFFFFFF8,   32'hFFFFFFFD,   {32'hFFFFFFFE, 32'd2},           0, 1};
      tbl[10] = '{0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'd0},           0, 0};
      tbl[11] = '{1, 32'h80000000,   32'd0,          64'd0,                           1, 0};

      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
      opdata1_i = '0; opdata2_i = '0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_res", result_o, 64'd0);
      check("rst_rdy", 64'(ready_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_dbz", 64'(div_by_zero_o), 64'd0);
      check("rst_res8", 64'(res8), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++)
         run_vec($sformatf("tbl%0d", i), tbl[i].sg, tbl[i].a, tbl[i].b,
                 tbl[i].exp_res, tbl[i].exp_dbz, tbl[i].hold);

      // Annul mid-divide, then a start blocked by annul, then a clean 50/5.
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1; start_i = 1'b0;
      @(posedge clk); #1;
      check("annul_busy", 64'(busy_o), 64'd0);
      check("annul_rdy", 64'(ready_o), 64'd0);
      @(negedge clk);
      start_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
      @(posedge clk); #1;
      check("annul_block_busy", 64'(busy_o), 64'd0);
      check("annul_block_rdy", 64'(ready_o), 64'd0);
      run_vec("after_annul", 0, 32'd50, 32'd5, {32'd0, 32'd10}, 0, 0);

      // Reset mid-ON with start held through it; the held request restarts.
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_res", result_o, 64'd0);
      check("midrst_rdy", 64'(ready_o), 64'd0);
      check("midrst_busy", 64'(busy_o), 64'd0);
      check("midrst_dbz", 64'(div_by_zero_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      opdata1_i = 32'd9; opdata2_i = 32'd3; signed_div_i = 1'b0;
      finish_div("after_rst", {32'd0, 32'd3}, 0, model_lat(0, 32'd9, 32'd3), 0);

      // Narrow instance: 255/16 at WIDTH=8.
      begin
         int lat8;
         bit done8;
         @(negedge clk);
         a8 = 8'd255; b8 = 8'd16; start8 = 1'b1;
         lat8 = 0; done8 = 0;
         while (!done8 && lat8 < 50) begin
            @(posedge clk); #1;
            lat8++;
            if (rdy8) done8 = 1;
         end
         check("w8_res", 64'(res8), 64'({8'd15, 8'd15}));
         check("w8_lat", 64'(lat8), 64'd9);
         @(negedge clk);
         start8 = 1'b0;
         @(posedge clk); #1;
         check("w8_clr", 64'(res8), 64'd0);
      end

      for (int i = 0; i < 150; i++) begin
         bit          sg;
         logic [31:0] a, b;
         int          mode;
         sg   = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 3);
         a    = $urandom;
         b    = $urandom;
         case (mode)
            1: b = sg ? (32'd0 - 32'($urandom_range(1, 20))) : 32'($urandom_range(1, 20));
            2: a = 32'($urandom_range(0, 1000));
            3: b = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
            default: ;
         endcase
         run_vec($sformatf("rand%0d", i), sg, a, b, model_res(sg, a, b), (b == 32'd0), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
